// File: rtl/input_handshake_if.sv
// ---------------------------------------------------------------------------
// input_handshake_if
//   Core-side handshake bundle for the Input instruction receiver.
//
//   Input        core -> receiver  core is executing Input (level, held until Stall drops)
//   Input_Data   receiver -> core  {22'b0, captured switches}
//   Input_Ready  receiver -> core  one-cycle pulse, Input_Data just updated
//   Stall        receiver -> core  freeze PC/pipeline (combinational)
//   Waiting      receiver -> core  waiting for the user (drives the "In" prompt)
//
//   master: core side, slave: receiver side.
// ---------------------------------------------------------------------------
interface input_handshake_if;
    logic        Input;
    logic [31:0] Input_Data;
    logic        Input_Ready;
    logic        Stall;
    logic        Waiting;

    modport master (
        output Input,
        input  Input_Data,
        input  Input_Ready,
        input  Stall,
        input  Waiting
    );

    modport slave (
        input  Input,
        output Input_Data,
        output Input_Ready,
        output Stall,
        output Waiting
    );
endinterface

// File: rtl/input_handshake.sv
// ---------------------------------------------------------------------------
// input_handshake
//   Receiver for the MIPS Input instruction. Stalls the core while Input is
//   executing until the user presses Enter, then latches the board switches
//   into Input_Data and releases the stall for one cycle.
//   Owns synchronisation + debounce + press-edge detection of Enter and
//   synchronisation of the switch bus.
//
//   clk     system clock, rising edge
//   reset   synchronous, active-high
//   Enter   raw pushbutton (asynchronous, bouncing)
//   sw      raw board switches (asynchronous)
//   hs      handshake bundle to the core (slave side)
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   IDLE         | no request in progress
//   WAIT_PRESS   | request pending, waiting for a fresh Enter press
//   WAIT_RELEASE | request pending, Enter still held from earlier; wait release
//   DONE         | switches captured, stall released for this cycle
// ---------------------------------------------------------------------------
module input_handshake #(
    parameter int DEBOUNCE_CYCLES  = 50000,
    parameter bit ENTER_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Enter,
    input  logic [9:0]       sw,
    input_handshake_if.slave hs
);

    localparam int               CNT_W          = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             ENTER_RELEASED = ENTER_ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        DONE         = 2'd3
    } state_t;

    logic             enter_s1_q, enter_s1_d;
    logic             enter_s2_q, enter_s2_d;
    logic [9:0]       sw_s1_q, sw_s1_d;
    logic [9:0]       sw_s2_q, sw_s2_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_pulse_q, press_pulse_d;
    state_t           state_q, state_d;
    logic [31:0]      data_q, data_d;
    logic             ready_q, ready_d;
    logic             waiting_q, waiting_d;
    logic             enter_level;

    always_comb begin
        enter_s1_d = Enter;
        enter_s2_d = enter_s1_q;
        sw_s1_d    = sw;
        sw_s2_d    = sw_s1_q;

        // Normalise so that 1 always means "pressed".
        enter_level = ENTER_ACTIVE_LOW ? ~enter_s2_q : enter_s2_q;

        // A new level is accepted only after it has differed from the
        // debounced value for DEBOUNCE_CYCLES consecutive cycles.
        deb_d         = deb_q;
        cnt_d         = cnt_q;
        press_pulse_d = 1'b0;
        if (enter_level == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d         = ~deb_q;
            cnt_d         = '0;
            press_pulse_d = ~deb_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        state_d = state_q;
        data_d  = data_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A button still held from a previous request must be
                // released before it can satisfy a new one.
                if (hs.Input) begin
                    state_d = deb_q ? WAIT_RELEASE : WAIT_PRESS;
                end
            end
            WAIT_RELEASE: begin
                if (!hs.Input) begin
                    state_d = IDLE;
                end else if (!deb_q) begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                // Dropping Input wins over a coincident press: no capture.
                if (!hs.Input) begin
                    state_d = IDLE;
                end else if (press_pulse_q) begin
                    data_d  = {22'b0, sw_s2_q};
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        waiting_d = (state_d == WAIT_PRESS) || (state_d == WAIT_RELEASE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enter_s1_q    <= ENTER_RELEASED;
            enter_s2_q    <= ENTER_RELEASED;
            sw_s1_q       <= '0;
            sw_s2_q       <= '0;
            deb_q         <= 1'b0;
            cnt_q         <= '0;
            press_pulse_q <= 1'b0;
            state_q       <= IDLE;
            data_q        <= '0;
            ready_q       <= 1'b0;
            waiting_q     <= 1'b0;
        end else begin
            enter_s1_q    <= enter_s1_d;
            enter_s2_q    <= enter_s2_d;
            sw_s1_q       <= sw_s1_d;
            sw_s2_q       <= sw_s2_d;
            deb_q         <= deb_d;
            cnt_q         <= cnt_d;
            press_pulse_q <= press_pulse_d;
            state_q       <= state_d;
            data_q        <= data_d;
            ready_q       <= ready_d;
            waiting_q     <= waiting_d;
        end
    end

    // Combinational so the core freezes in the very cycle it issues Input.
    assign hs.Stall       = hs.Input && (state_q != DONE);
    assign hs.Input_Data  = data_q;
    assign hs.Input_Ready = ready_q;
    assign hs.Waiting     = waiting_q;

endmodule
